ccip_mmio_rsp_tracker: RTL and testbench

Checker stage sitting on the CCI-P MMIO path beside the transaction logger, fed by the same Rx0/Tx2 taps.
- Tracks every outstanding SW->AFU MMIO read (C0Rx MmioRd, keyed by tid) until the AFU's C2Tx MmioRdRsp returns it.
- Flags unexpected responses, duplicate tids, tracker overflow and response timeouts.
- Emits one encoded event per cycle to the logger's message path, plus sticky error flags for the ASE top-level.

---
 rtl/ccip_mmio_rsp_tracker_pkg.sv | 14 +
 rtl/ccip_mmio_slot_finder.sv | 18 +
 rtl/ccip_mmio_rsp_tracker.sv | 145 ++++++++++++++
 tb/tb_ccip_mmio_rsp_tracker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ccip_mmio_rsp_tracker_pkg.sv
// ccip_mmio_rsp_tracker_pkg: event codes and err_flags bit positions for the MMIO response tracker
package ccip_mmio_rsp_tracker_pkg;
  typedef enum logic [2:0] {
    EVT_NONE      = 3'd0,
    EVT_UNEXP_RSP = 3'd1,
    EVT_DUP_TID   = 3'd2,
    EVT_OVERFLOW  = 3'd3,
    EVT_TIMEOUT   = 3'd4
  } mmio_evt_t;
  localparam int MMIO_ERR_UNEXP_RSP = 0;
  localparam int MMIO_ERR_DUP_TID   = 1;
  localparam int MMIO_ERR_OVERFLOW  = 2;
  localparam int MMIO_ERR_TIMEOUT   = 3;
endpackage

// File: rtl/ccip_mmio_slot_finder.sv
// ccip_mmio_slot_finder: lowest-set-bit priority encoder over a slot vector
//   i_vec   : candidate slot bits
//   o_idx   : index of the lowest set bit (0 when none set)
//   o_found : any bit set
module ccip_mmio_slot_finder #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? IW'(i) : o_idx;
  end
  assign o_found = |i_vec;
endmodule

// File: rtl/ccip_mmio_rsp_tracker.sv
// ccip_mmio_rsp_tracker: tracks outstanding CCI-P MMIO reads by tid and reports protocol errors
//   clk, rst_n           : CCI clock, async active-low reset
//   SoftReset            : sync flush of table, flags and event outputs
//   C0RxMmioRdValid/Tid  : MMIO read request tap
//   C2TxMmioRdValid/Tid  : MMIO read response tap
//   event_valid/code/tid : one registered event per cycle
//   outstanding          : registered count of valid slots
//   err_flags            : sticky {TIMEOUT, OVERFLOW, DUP_TID, UNEXP_RSP}
//   rsp_count/max_latency: only when CCIP_MMIO_LATENCY_STATS_EN is defined
module ccip_mmio_rsp_tracker
  import ccip_mmio_rsp_tracker_pkg::*;
#(
  parameter int NUM_SLOTS      = 16,
  parameter int TID_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int AGE_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             SoftReset,
  input  logic                             C0RxMmioRdValid,
  input  logic [TID_WIDTH-1:0]             C0RxMmioTid,
  input  logic                             C2TxMmioRdValid,
  input  logic [TID_WIDTH-1:0]             C2TxTid,
  output logic                             event_valid,
  output logic [2:0]                       event_code,
  output logic [TID_WIDTH-1:0]             event_tid,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   outstanding,
  output logic [3:0]                       err_flags
`ifdef CCIP_MMIO_LATENCY_STATS_EN
  ,
  output logic [31:0]                      rsp_count,
  output logic [AGE_WIDTH-1:0]             max_latency
`endif
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int OW = $clog2(NUM_SLOTS + 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(TIMEOUT_CYCLES);
  logic [NUM_SLOTS-1:0] r_valid;
  logic [TID_WIDTH-1:0] r_tid [NUM_SLOTS];
  logic [AGE_WIDTH-1:0] r_age [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_rsp_hit, w_dup_hit, w_exp, w_clr;
  logic [IW-1:0]        w_free_idx, w_rsp_idx, w_exp_idx;
  logic                 w_free_found, w_rsp_found, w_exp_found;
  logic                 w_unexp, w_dup, w_ovf, w_alloc, w_to_win;
  logic [3:0]           w_err;
  mmio_evt_t            w_code;
  logic [TID_WIDTH-1:0] w_etid;
  logic [OW-1:0]        w_count;
  // A slot matched by this cycle's response is neither a duplicate nor a timeout candidate.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_rsp_hit[i] = C2TxMmioRdValid && r_valid[i] && r_tid[i] == C2TxTid;
      w_dup_hit[i] = r_valid[i] && !w_rsp_hit[i] && r_tid[i] == C0RxMmioTid;
      w_exp[i]     = r_valid[i] && !w_rsp_hit[i] && r_age[i] == AGE_MAX;
    end
  end
  ccip_mmio_slot_finder #(.N(NUM_SLOTS)) u_free (.i_vec(~r_valid), .o_idx(w_free_idx), .o_found(w_free_found));
  ccip_mmio_slot_finder #(.N(NUM_SLOTS)) u_rsp  (.i_vec(w_rsp_hit), .o_idx(w_rsp_idx),  .o_found(w_rsp_found));
  ccip_mmio_slot_finder #(.N(NUM_SLOTS)) u_exp  (.i_vec(w_exp),     .o_idx(w_exp_idx),  .o_found(w_exp_found));
  assign w_unexp  = C2TxMmioRdValid && !w_rsp_found;
  assign w_dup    = C0RxMmioRdValid && |w_dup_hit;
  assign w_ovf    = C0RxMmioRdValid && !w_dup && !w_free_found;
  assign w_alloc  = C0RxMmioRdValid && !w_dup && w_free_found;
  // A timeout only consumes its slot when it wins the event arbitration.
  assign w_to_win = w_exp_found && !w_unexp && !w_dup && !w_ovf;
  assign w_code   = w_unexp ? EVT_UNEXP_RSP : w_dup ? EVT_DUP_TID : w_ovf ? EVT_OVERFLOW :
                    w_exp_found ? EVT_TIMEOUT : EVT_NONE;
  assign w_etid   = w_unexp ? C2TxTid : (w_dup || w_ovf) ? C0RxMmioTid :
                    w_exp_found ? r_tid[w_exp_idx] : '0;
  always_comb begin
    w_err = '0;
    w_err[MMIO_ERR_UNEXP_RSP] = w_unexp;
    w_err[MMIO_ERR_DUP_TID]   = w_dup;
    w_err[MMIO_ERR_OVERFLOW]  = w_ovf;
    w_err[MMIO_ERR_TIMEOUT]   = w_exp_found;
  end
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_clr[i] = (w_rsp_found && w_rsp_idx == IW'(i)) || (w_to_win && w_exp_idx == IW'(i));
      w_count  = w_count + OW'((r_valid[i] && !w_clr[i]) || (w_alloc && w_free_idx == IW'(i)));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_tid[i] <= '0;
        r_age[i] <= '0;
      end
      event_valid <= 1'b0;
      event_code  <= EVT_NONE;
      event_tid   <= '0;
      outstanding <= '0;
      err_flags   <= '0;
    end else if (SoftReset) begin
      r_valid     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_tid[i] <= '0;
        r_age[i] <= '0;
      end
      event_valid <= 1'b0;
      event_code  <= EVT_NONE;
      event_tid   <= '0;
      outstanding <= '0;
      err_flags   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_alloc && w_free_idx == IW'(i)) begin
          r_valid[i] <= 1'b1;
          r_tid[i]   <= C0RxMmioTid;
          r_age[i]   <= AGE_WIDTH'(1);
        end else if (w_clr[i]) begin
          r_valid[i] <= 1'b0;
          r_tid[i]   <= '0;
          r_age[i]   <= '0;
        end else if (r_valid[i] && r_age[i] != AGE_MAX) begin
          r_age[i]   <= r_age[i] + 1'b1;
        end
      end
      event_valid <= w_code != EVT_NONE;
      event_code  <= w_code;
      event_tid   <= w_etid;
      outstanding <= w_count;
      err_flags   <= err_flags | w_err;
    end
  end
`ifdef CCIP_MMIO_LATENCY_STATS_EN
  logic [AGE_WIDTH-1:0] w_hit_age;
  assign w_hit_age = r_age[w_rsp_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count   <= '0;
      max_latency <= '0;
    end else if (SoftReset) begin
      rsp_count   <= '0;
      max_latency <= '0;
    end else if (w_rsp_found) begin
      rsp_count   <= rsp_count + 32'd1;
      max_latency <= w_hit_age > max_latency ? w_hit_age : max_latency;
    end
  end
`endif
endmodule

// File: tb/tb_ccip_mmio_rsp_tracker.sv
// tb_ccip_mmio_rsp_tracker: directed table, corner sequences and randomized model check of the tracker
module tb_ccip_mmio_rsp_tracker;
  localparam int NS = 16;
  localparam int TW = 9;
  localparam int TO = 20;
  localparam int AW = $clog2(TO + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sr = 1'b0, qv = 1'b0, pv = 1'b0;
  logic [TW-1:0] qt = '0, pt = '0;
  logic ev;
  logic [2:0] code;
  logic [TW-1:0] etid;
  logic [4:0] outs;
  logic [3:0] err;
`ifdef CCIP_MMIO_LATENCY_STATS_EN
  logic [31:0] rcnt;
  logic [AW-1:0] mlat;
`endif
  int nvec = 0, nbad = 0;
  ccip_mmio_rsp_tracker #(.NUM_SLOTS(NS), .TID_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .SoftReset(sr),
    .C0RxMmioRdValid(qv), .C0RxMmioTid(qt),
    .C2TxMmioRdValid(pv), .C2TxTid(pt),
    .event_valid(ev), .event_code(code), .event_tid(etid),
    .outstanding(outs), .err_flags(err)
`ifdef CCIP_MMIO_LATENCY_STATS_EN
    , .rsp_count(rcnt), .max_latency(mlat)
`endif
  );
  always #5 clk = ~clk;
  // reference model: set of outstanding requests with their ages
  bit m_v [NS];
  int m_t [NS];
  int m_a [NS];
  bit e_ev;
  int e_code, e_tid, e_out, m_cnt, m_max;
  bit [3:0] e_err;
  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input bit rq, input int rqt, input bit rp, input int rpt, input bit s);
    int hit = -1, fr = -1, ex = -1;
    bit unexp, dup = 0, ovf;
    if (s) begin
      foreach (m_v[i]) begin m_v[i] = 0; m_a[i] = 0; end
      e_ev = 0; e_code = 0; e_tid = 0; e_out = 0; e_err = 0; m_cnt = 0; m_max = 0;
      return;
    end
    foreach (m_v[i]) if (rp && m_v[i] && m_t[i] == rpt) hit = i;
    unexp = rp && hit < 0;
    foreach (m_v[i]) if (rq && m_v[i] && i != hit && m_t[i] == rqt) dup = 1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!m_v[i]) fr = i;
      if (m_v[i] && i != hit && m_a[i] == TO) ex = i;
    end
    ovf = rq && !dup && fr < 0;
    e_err |= {ex >= 0, ovf, dup, unexp};
    e_ev = unexp || dup || ovf || ex >= 0;
    e_code = unexp ? 1 : dup ? 2 : ovf ? 3 : ex >= 0 ? 4 : 0;
    e_tid = unexp ? rpt : (dup || ovf) ? rqt : ex >= 0 ? m_t[ex] : 0;
    if (hit >= 0) begin
      m_cnt++;
      if (m_a[hit] > m_max) m_max = m_a[hit];
      m_v[hit] = 0;
    end
    if (e_code == 4) m_v[ex] = 0;
    foreach (m_v[i]) if (m_v[i] && m_a[i] < TO) m_a[i]++;
    if (rq && !dup && fr >= 0) begin m_v[fr] = 1; m_t[fr] = rqt; m_a[fr] = 1; end
    e_out = 0;
    foreach (m_v[i]) e_out += int'(m_v[i]);
  endtask
  task automatic step(input bit rq, input int rqt, input bit rp, input int rpt, input bit s);
    qv = rq; qt = TW'(rqt); pv = rp; pt = TW'(rpt); sr = s;
    model_step(rq, rqt, rp, rpt, s);
    @(posedge clk);
    #1;
    qv = 0; pv = 0; sr = 0;
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, ev, e_ev);
    chk({tag, ".code"}, code, e_code);
    chk({tag, ".tid"}, etid, e_tid);
    chk({tag, ".outstanding"}, outs, e_out);
    chk({tag, ".err_flags"}, err, e_err);
`ifdef CCIP_MMIO_LATENCY_STATS_EN
    chk({tag, ".rsp_count"}, rcnt, m_cnt);
    chk({tag, ".max_latency"}, mlat, m_max);
`endif
  endtask
  typedef struct {
    bit rq; int rqt; bit rp; int rpt; bit s;
    bit x_ev; int x_code; int x_tid; int x_out; int x_err;
  } vec_t;
  vec_t tv [18];
  initial begin
    tv[0]  = '{0, 0,     0, 0,     0, 0, 0, 0,     0, 0};
    tv[1]  = '{1, 'h005, 0, 0,     0, 0, 0, 0,     1, 0};
    tv[2]  = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 0};
    tv[3]  = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 0};
    tv[4]  = '{0, 0,     1, 'h005, 0, 0, 0, 0,     0, 0};
    tv[5]  = '{0, 0,     1, 'h033, 0, 1, 1, 'h033, 0, 1};
    tv[6]  = '{0, 0,     0, 0,     0, 0, 0, 0,     0, 1};
    tv[7]  = '{1, 'h010, 0, 0,     0, 0, 0, 0,     1, 1};
    tv[8]  = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 1};
    tv[9]  = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 1};
    tv[10] = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 1};
    tv[11] = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 1};
    tv[12] = '{1, 'h010, 0, 0,     0, 1, 2, 'h010, 1, 3};
    tv[13] = '{0, 0,     0, 0,     0, 0, 0, 0,     1, 3};
    tv[14] = '{0, 0,     1, 'h010, 0, 0, 0, 0,     0, 3};
    tv[15] = '{1, 'h044, 1, 'h044, 0, 1, 1, 'h044, 1, 3};
    tv[16] = '{1, 'h055, 0, 0,     1, 0, 0, 0,     0, 0};
    tv[17] = '{0, 0,     1, 'h044, 0, 1, 1, 'h044, 0, 1};
    model_step(0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", ev, 0);
    chk("reset.code", code, 0);
    chk("reset.tid", etid, 0);
    chk("reset.outstanding", outs, 0);
    chk("reset.err_flags", err, 0);
    rst_n = 1'b1;
    foreach (tv[k]) begin
      step(tv[k].rq, tv[k].rqt, tv[k].rp, tv[k].rpt, tv[k].s);
      chk($sformatf("tbl%0d.valid", k), ev, tv[k].x_ev);
      chk($sformatf("tbl%0d.code", k), code, tv[k].x_code);
      chk($sformatf("tbl%0d.tid", k), etid, tv[k].x_tid);
      chk($sformatf("tbl%0d.outstanding", k), outs, tv[k].x_out);
      chk($sformatf("tbl%0d.err_flags", k), err, tv[k].x_err);
    end
    // overflow: 17 requests with distinct tids, no responses
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) begin step(1, k, 0, 0, 0); chk_model($sformatf("ovf%0d", k)); end
    chk("ovf.code", code, 3);
    chk("ovf.tid", etid, 'h010);
    chk("ovf.outstanding", outs, 16);
    chk("ovf.err_ovf", err[2], 1);
    // timeout: two requests, no responses, expiries reported on consecutive cycles
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    for (int k = 0; k < 3 * TO && !ev; k++) begin step(0, 0, 0, 0, 0); chk_model("to_wait"); end
    chk("to1.valid", ev, 1);
    chk("to1.code", code, 4);
    chk("to1.tid", etid, 1);
    step(0, 0, 0, 0, 0);
    chk("to2.code", code, 4);
    chk("to2.tid", etid, 2);
    chk("to2.outstanding", outs, 0);
    chk("to2.err_to", err[3], 1);
    step(0, 0, 0, 0, 0);
    chk("to3.valid", ev, 0);
    // flush mid-flight turns the later response into an unexpected one
    step(1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_model("flush");
    step(0, 0, 1, 7, 0);
    chk("flush.code", code, 1);
    chk("flush.tid", etid, 7);
    chk("flush.outstanding", outs, 0);
`ifdef CCIP_MMIO_LATENCY_STATS_EN
    chk("flush.rsp_count", rcnt, 0);
`endif
    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < 60, $urandom_range(23), $urandom_range(99) < 35,
           $urandom_range(23), $urandom_range(299) == 0);
      chk_model("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
